itu656_rx_decoder: RTL and testbench
====================================

# itu656_rx_decoder

Receive-side decoder for the 8-bit ITU-R BT.656 byte stream produced by `sd_source` and by external CVBS decoder chips. It finds timing reference signals (TRS: FF 00 00 XY), checks the XY protection bits, and recovers F/V/H flags. It de-interleaves active-video bytes into 16-bit Y/C 4:2:2 pixel words, and reports a lock status based on consecutive well-formed lines. One instance sits in front of each of the four capture channels of the quad CVBS display path.

## Interface
Parameters:
- `ACTIVE_PIXELS`, 720: Y samples per active line; a well-formed line carries exactly 2*ACTIVE_PIXELS active bytes.
- `LOCK_LINES`, 4: consecutive well-formed lines required to assert `o_lock`.

Ports:
- `clk_in`  in  1  byte clock (27 MHz), the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `i_itu_656_data_8b`  in  8  BT.656 byte stream, one byte per `clk_in`.
- `o_ycbcr_16b`  out  16  [15:8] = Y, [7:0] = Cb or Cr co-sited with that Y.
- `o_valid`  out  1  `o_ycbcr_16b` holds a new pixel this cycle.
- `o_de`  out  1  active-video window.
- `o_hs`  out  1  H flag of the last accepted XY (1 = blanking after EAV).
- `o_vs`  out  1  V flag of the last accepted XY.
- `o_field`  out  1  F flag of the last accepted XY.
- `o_xy_err`  out  1  one-cycle pulse: XY protection mismatch.
- `o_lock`  out  1  LOCK_LINES consecutive good lines received.

## Operation
- Input byte is registered once (stage d0). A 3-byte history (d1..d3) detects a preamble: d3,d2,d1 = FF,00,00. When this matches, d0 is XY.
- XY decode: bit7 = 1, F = bit6, V = bit5, H = bit4. P3 = V^H, P2 = F^H, P1 = F^V, P0 = F^V^H.
- XY is accepted only if bit7 = 1 and P3..P0 match. On acceptance, `o_field`/`o_vs`/`o_hs` load F/V/H.
- On mismatch: pulse `o_xy_err`, leave the flags unchanged, do not start active video, and mark the line bad.
- State machine:
  - BLANK -> ACTIVE on an accepted SAV with H = 0 and V = 0. The byte phase counter (0 = Cb, 1 = Y, 2 = Cr, 3 = Y) and the 12-bit byte counter clear.
  - SAV with V = 1 stays in BLANK.
  - ACTIVE -> BLANK on any 0xFF byte. BT.656 forbids 0xFF in active video, so this byte is the start of EAV and is not counted as active.
- In ACTIVE, a Cb or Cr byte is held in a chroma register. On each Y byte, `o_ycbcr_16b` <= {Y, held chroma} and `o_valid` = 1. First word of a line = {Y0, Cb0}, second = {Y1, Cr0}.
- Line check on an accepted EAV (H = 1):
  - The line is good if the preceding ACTIVE byte count = 2*ACTIVE_PIXELS and no XY error occurred since the previous EAV.
  - EAVs of V = 1 lines count as good if their XY is valid; no byte-count check applies to them.
- Lock counter (3 bits, saturates at LOCK_LINES):
  - Increments on a good line; `o_lock` = 1 when it equals LOCK_LINES.
  - A bad line clears the counter and `o_lock` immediately (registered on that EAV).
- Byte counter saturates at 4095, so overlong lines cannot wrap back into a "good" count.
- Simultaneous events: an XY error on an EAV both pulses `o_xy_err` and clears lock in the same cycle.
- Reset (any time, including mid-line):
  - All outputs 0; state BLANK; history registers 0 (no false preamble); lock counter 0.
  - The first accepted SAV after reset re-establishes timing.

## Timing
- Latency: 2 `clk_in` from a byte on `i_itu_656_data_8b` to its effect on any output. This applies to XY flags, `o_xy_err`, `o_lock`, and pixel words.
- If XY (SAV) is on the pins at edge n, then Cb0 is at n+1, Y0 at n+2, and the first `o_valid` is high in the cycle after edge n+3.
- `o_valid` pulses every second cycle during ACTIVE, giving ACTIVE_PIXELS pulses per good line.
- `o_de` is high for exactly 2*ACTIVE_PIXELS consecutive cycles per active line. It is aligned so the first `o_valid` falls in the second `o_de` cycle and the last `o_valid` falls in the last `o_de` cycle.
- `o_xy_err` is exactly 1 cycle wide per bad XY.
- No backpressure: a downstream consumer must accept every `o_valid`.

## Test plan
- Reset: hold `rst` 4 cycles with random data -> all outputs 0; release, drive 00 bytes -> outputs stay 0.
- One active line: FF 00 00 80, 1440 bytes (Cb = 0x10+k, Y = 0x40+k pattern), FF 00 00 9D. Required response:
  - 720 `o_valid` pulses; first word {Y0, 0x10}, second {Y1, Cr0}.
  - `o_de` high 1440 cycles; `o_hs` rises 2 cycles after the 9D byte.
- Blanking/field flags: SAV 0xAB -> `o_vs` = 1, no `o_de`. SAV 0xC7 -> `o_field` = 1, `o_vs` = 0, and an active line is decoded. EAV 0xDA keeps `o_field` = 1.
- Protection error: FF 00 00 81 -> one-cycle `o_xy_err`, flags unchanged, no `o_valid` for the following bytes.
- Lock: 4 good lines -> `o_lock` rises 2 cycles after the 4th EAV. A 719-pixel line then EAV -> `o_lock` falls 2 cycles after that EAV.
- Mid-line reset: assert `rst` after 300 pixels -> `o_de`/`o_valid` drop next edge. Remaining bytes of that line produce no output; the next SAV 0x80 decodes normally.

Source files
------------

// File: rtl/itu656_rx_decoder.sv
// BT.656 receive decoder: finds TRS preambles, validates XY, recovers F/V/H,
// de-interleaves active video into {Y, C} words and tracks line lock.
module itu656_rx_decoder #(
  parameter int unsigned ACTIVE_PIXELS = 720,
  parameter int unsigned LOCK_LINES    = 4
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic [7:0]  i_itu_656_data_8b,
  output logic [15:0] o_ycbcr_16b,
  output logic        o_valid,
  output logic        o_de,
  output logic        o_hs,
  output logic        o_vs,
  output logic        o_field,
  output logic        o_xy_err,
  output logic        o_lock
);

  localparam logic [11:0] LineBytes = 12'(2 * ACTIVE_PIXELS);
  localparam logic [2:0]  LockMax   = 3'(LOCK_LINES);

  typedef enum logic {StBlank, StActive} state_e;

  state_e      state_q, state_d;
  logic [7:0]  d0_q, d1_q, d2_q, d3_q;
  logic [1:0]  phase_q, phase_d;
  logic [11:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]  chroma_q, chroma_d;
  logic [15:0] pix_q, pix_d;
  logic        valid_q, valid_d;
  logic        de_q, de_d;
  logic        field_q, field_d;
  logic        vs_q, vs_d;
  logic        hs_q, hs_d;
  logic        xy_err_q, xy_err_d;
  logic        line_bad_q, line_bad_d;
  logic [2:0]  lock_cnt_q, lock_cnt_d;

  logic trs_hit;
  logic xy_f, xy_v, xy_h;
  logic xy_ok;
  logic xy_accept, xy_bad;
  logic line_good;

  assign trs_hit   = (d3_q == 8'hFF) && (d2_q == 8'h00) && (d1_q == 8'h00);
  assign xy_f      = d0_q[6];
  assign xy_v      = d0_q[5];
  assign xy_h      = d0_q[4];
  assign xy_ok     = d0_q[7] &&
                     (d0_q[3:0] == {xy_v ^ xy_h, xy_f ^ xy_h, xy_f ^ xy_v, xy_f ^ xy_v ^ xy_h});
  assign xy_accept = trs_hit && xy_ok;
  assign xy_bad    = trs_hit && !xy_ok;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    byte_cnt_d = byte_cnt_q;
    chroma_d   = chroma_q;
    pix_d      = pix_q;
    valid_d    = 1'b0;
    de_d       = 1'b0;
    field_d    = field_q;
    vs_d       = vs_q;
    hs_d       = hs_q;
    xy_err_d   = 1'b0;
    line_bad_d = line_bad_q;
    lock_cnt_d = lock_cnt_q;
    line_good  = 1'b0;

    if (state_q == StActive) begin
      // 0xFF cannot occur in active video, so it is the first EAV byte.
      if (d0_q == 8'hFF) begin
        state_d = StBlank;
      end else begin
        de_d    = 1'b1;
        phase_d = phase_q + 2'd1;
        if (byte_cnt_q != 12'hFFF) begin
          byte_cnt_d = byte_cnt_q + 12'd1;
        end
        if (phase_q[0]) begin
          pix_d   = {d0_q, chroma_q};
          valid_d = 1'b1;
        end else begin
          chroma_d = d0_q;
        end
      end
    end

    if (xy_accept) begin
      field_d = xy_f;
      vs_d    = xy_v;
      hs_d    = xy_h;
      if (!xy_h && !xy_v) begin
        state_d    = StActive;
        phase_d    = 2'd0;
        byte_cnt_d = '0;
      end
      if (xy_h) begin
        line_good  = xy_v || ((byte_cnt_q == LineBytes) && !line_bad_q);
        lock_cnt_d = line_good ? ((lock_cnt_q < LockMax) ? lock_cnt_q + 3'd1 : LockMax) : '0;
        byte_cnt_d = '0;
        line_bad_d = 1'b0;
      end
    end

    if (xy_bad) begin
      xy_err_d = 1'b1;
      // A corrupt EAV ends the line as bad; a corrupt SAV taints the line in progress.
      if (d0_q[4]) begin
        lock_cnt_d = '0;
        byte_cnt_d = '0;
        line_bad_d = 1'b0;
      end else begin
        line_bad_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q    <= StBlank;
      d0_q       <= '0;
      d1_q       <= '0;
      d2_q       <= '0;
      d3_q       <= '0;
      phase_q    <= '0;
      byte_cnt_q <= '0;
      chroma_q   <= '0;
      pix_q      <= '0;
      valid_q    <= 1'b0;
      de_q       <= 1'b0;
      field_q    <= 1'b0;
      vs_q       <= 1'b0;
      hs_q       <= 1'b0;
      xy_err_q   <= 1'b0;
      line_bad_q <= 1'b0;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      d0_q       <= i_itu_656_data_8b;
      d1_q       <= d0_q;
      d2_q       <= d1_q;
      d3_q       <= d2_q;
      phase_q    <= phase_d;
      byte_cnt_q <= byte_cnt_d;
      chroma_q   <= chroma_d;
      pix_q      <= pix_d;
      valid_q    <= valid_d;
      de_q       <= de_d;
      field_q    <= field_d;
      vs_q       <= vs_d;
      hs_q       <= hs_d;
      xy_err_q   <= xy_err_d;
      line_bad_q <= line_bad_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  assign o_ycbcr_16b = pix_q;
  assign o_valid     = valid_q;
  assign o_de        = de_q;
  assign o_hs        = hs_q;
  assign o_vs        = vs_q;
  assign o_field     = field_q;
  assign o_xy_err    = xy_err_q;
  assign o_lock      = (lock_cnt_q == LockMax);

endmodule

// File: tb/tb_itu656_rx_decoder.sv
// Bench for itu656_rx_decoder: XY decode table, directed line/lock/reset
// sequences, and randomized lines checked against a line-level model.
module tb_itu656_rx_decoder;

  localparam int ActivePixels = 720;
  localparam int LockLines    = 4;

  logic        clk;
  logic        rst;
  logic [7:0]  din;
  logic [15:0] o_ycbcr_16b;
  logic        o_valid, o_de, o_hs, o_vs, o_field, o_xy_err, o_lock;

  itu656_rx_decoder #(
    .ACTIVE_PIXELS(ActivePixels),
    .LOCK_LINES   (LockLines)
  ) dut (
    .clk_in           (clk),
    .rst              (rst),
    .i_itu_656_data_8b(din),
    .o_ycbcr_16b      (o_ycbcr_16b),
    .o_valid          (o_valid),
    .o_de             (o_de),
    .o_hs             (o_hs),
    .o_vs             (o_vs),
    .o_field          (o_field),
    .o_xy_err         (o_xy_err),
    .o_lock           (o_lock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] xy;
    logic       err;
    logic [2:0] fvh;
    logic       de;
  } xy_vec_t;

  xy_vec_t     tbl[10];
  int          checks, failures;
  int          mon_err, err_pulses, m_err;
  int          m_lock;
  logic [2:0]  m_fvh;
  logic [15:0] got_words[$], exp_words[$];
  int          got_de[$], exp_de[$];
  int          lens[6] = '{1438, 1439, 1441, 1442, 1444, 600};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor: collects words and DE run lengths, polices VALID/DE alignment.
  initial begin
    int  de_run;
    bit  prev_err;
    de_run   = 0;
    prev_err = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        de_run   = 0;
        prev_err = 1'b0;
      end else begin
        if (o_de) begin
          de_run++;
        end else if (de_run != 0) begin
          got_de.push_back(de_run);
          de_run = 0;
        end
        if (o_valid) begin
          got_words.push_back(o_ycbcr_16b);
          if (!o_de || (de_run % 2) != 0) mon_err++;
        end
        if (o_xy_err) begin
          err_pulses++;
          if (prev_err) mon_err++;
        end
        prev_err = o_xy_err;
      end
    end
  end

  function automatic bit legal(input logic [7:0] xy);
    case (xy)
      8'h80, 8'h9D, 8'hAB, 8'hB6, 8'hC7, 8'hDA, 8'hEC, 8'hF1: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] pat(input int j);
    int k;
    k = j / 4;
    case (j % 4)
      0:       return 8'(16 + (k % 224));
      2:       return 8'(32 + (k % 208));
      default: return 8'(64 + ((j / 2) % 160));
    endcase
  endfunction

  task automatic send_byte(input logic [7:0] b);
    din = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_trs(input logic [7:0] xy);
    send_byte(8'hFF);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(xy);
  endtask

  task automatic clear_q();
    got_words.delete();
    exp_words.delete();
    got_de.delete();
    exp_de.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) send_byte(8'($urandom));
    rst = 1'b0;
    m_lock = 0;
    m_fvh  = 3'b000;
    clear_q();
  endtask

  task automatic cmp_queues(input string tag);
    int nbad;
    chk({tag, "_words_n"}, got_words.size(), exp_words.size());
    nbad = 0;
    for (int i = 0; i < got_words.size() && i < exp_words.size(); i++)
      if (got_words[i] !== exp_words[i]) nbad++;
    chk({tag, "_words_data"}, nbad, 0);
    chk({tag, "_de_n"}, got_de.size(), exp_de.size());
    nbad = 0;
    for (int i = 0; i < got_de.size() && i < exp_de.size(); i++)
      if (got_de[i] != exp_de[i]) nbad++;
    chk({tag, "_de_len"}, nbad, 0);
    clear_q();
  endtask

  // One line: SAV, nbytes payload, EAV; expectations from the line-level rules.
  task automatic run_line(input logic [7:0] sav, input int nbytes, input logic [7:0] eav,
                          input bit rnd, input string tag);
    logic [7:0] b[$];
    bit         sav_ok, eav_ok, act, good, lock_before;
    logic [2:0] fvh_before;
    sav_ok = legal(sav);
    eav_ok = legal(eav);
    act    = sav_ok && (sav[5:4] == 2'b00);
    if (sav_ok) m_fvh = sav[6:4];
    fvh_before  = m_fvh;
    lock_before = (m_lock == LockLines);
    for (int j = 0; j < nbytes; j++) b.push_back(rnd ? 8'($urandom_range(1, 254)) : pat(j));
    if (act) begin
      for (int i = 0; i < nbytes / 2; i++) exp_words.push_back({b[2*i+1], b[2*i]});
      exp_de.push_back(nbytes);
    end
    if (!sav_ok) m_err++;
    if (!eav_ok) m_err++;
    send_trs(sav);
    foreach (b[j]) send_byte(b[j]);
    send_trs(eav);
    good   = eav_ok && (eav[5] || (act && nbytes == 2 * ActivePixels));
    m_lock = good ? ((m_lock < LockLines) ? m_lock + 1 : LockLines) : 0;
    if (eav_ok) m_fvh = eav[6:4];
    chk({tag, "_lock_hold"}, o_lock, lock_before);
    chk({tag, "_fvh_hold"}, {o_field, o_vs, o_hs}, fvh_before);
    send_byte(8'h10);
    chk({tag, "_lock"}, o_lock, m_lock == LockLines);
    chk({tag, "_fvh"}, {o_field, o_vs, o_hs}, m_fvh);
    send_byte(8'h80);
    cmp_queues(tag);
  endtask

  initial begin
    checks = 0; failures = 0; mon_err = 0; err_pulses = 0; m_err = 0;
    m_lock = 0; m_fvh = 3'b000;
    rst = 1'b1;
    din = 8'h00;

    tbl[0] = '{8'hAB, 1'b0, 3'b010, 1'b0};
    tbl[1] = '{8'h81, 1'b1, 3'b010, 1'b0};
    tbl[2] = '{8'hF1, 1'b0, 3'b111, 1'b0};
    tbl[3] = '{8'h00, 1'b1, 3'b111, 1'b0};
    tbl[4] = '{8'hC7, 1'b0, 3'b100, 1'b1};
    tbl[5] = '{8'hDA, 1'b0, 3'b101, 1'b0};
    tbl[6] = '{8'h80, 1'b0, 3'b000, 1'b1};
    tbl[7] = '{8'h9C, 1'b1, 3'b000, 1'b0};
    tbl[8] = '{8'hEC, 1'b0, 3'b110, 1'b0};
    tbl[9] = '{8'hB6, 1'b0, 3'b011, 1'b0};

    // Reset with a preamble on the pins must not leave a live history.
    send_byte(8'($urandom));
    send_byte(8'hFF);
    send_byte(8'h00);
    send_byte(8'h00);
    chk("reset_outputs", {o_ycbcr_16b, o_valid, o_de, o_hs, o_vs, o_field, o_xy_err, o_lock}, 0);
    rst = 1'b0;
    send_byte(8'h80);
    for (int i = 0; i < 6; i++) begin
      send_byte(8'h00);
      chk("idle_outputs", {o_ycbcr_16b, o_valid, o_de, o_hs, o_vs, o_field, o_xy_err, o_lock}, 0);
    end

    foreach (tbl[i]) begin
      send_trs(tbl[i].xy);
      send_byte(8'h10);
      chk($sformatf("xy%02h_err", tbl[i].xy), o_xy_err, tbl[i].err);
      chk($sformatf("xy%02h_fvh", tbl[i].xy), {o_field, o_vs, o_hs}, tbl[i].fvh);
      send_byte(8'h80);
      chk($sformatf("xy%02h_de", tbl[i].xy), o_de, tbl[i].de);
    end

    do_reset();
    err_pulses = 0;
    m_err      = 0;

    run_line(8'h80, 1440, 8'h9D, 1'b0, "line1");
    run_line(8'h80, 1440, 8'h9D, 1'b0, "line2");
    run_line(8'hC7, 1440, 8'hDA, 1'b0, "line3");
    run_line(8'hC7, 1440, 8'hDA, 1'b0, "line4");
    run_line(8'h80, 1438, 8'h9D, 1'b0, "short");
    run_line(8'h80, 1440, 8'h9D, 1'b0, "relock1");
    run_line(8'h80, 1440, 8'h9D, 1'b0, "relock2");
    run_line(8'h80, 1440, 8'h9D, 1'b0, "relock3");
    // 1440 + 4096 bytes would alias to a good count without saturation.
    run_line(8'h80, 5536, 8'h9D, 1'b0, "overlong");

    // Mid-line reset after 300 pixels.
    do_reset();
    send_trs(8'h80);
    for (int j = 0; j < 600; j++) send_byte(pat(j));
    for (int i = 0; i < 299; i++) exp_words.push_back({pat(2*i+1), pat(2*i)});
    chk("mid_de_before", o_de, 1);
    rst = 1'b1;
    send_byte(pat(600));
    chk("mid_reset_drop", {o_de, o_valid}, 0);
    rst = 1'b0;
    chk("mid_words_n", got_words.size(), exp_words.size());
    begin
      int nbad;
      nbad = 0;
      for (int i = 0; i < got_words.size() && i < exp_words.size(); i++)
        if (got_words[i] !== exp_words[i]) nbad++;
      chk("mid_words_data", nbad, 0);
    end
    clear_q();
    for (int j = 601; j < 1440; j++) send_byte(pat(j));
    send_trs(8'h9D);
    send_byte(8'h10);
    send_byte(8'h80);
    m_fvh = 3'b001;
    chk("mid_tail_words", got_words.size(), 0);
    chk("mid_tail_de", got_de.size(), 0);
    chk("mid_tail_lock", o_lock, 0);
    clear_q();
    run_line(8'h80, 1440, 8'h9D, 1'b0, "post_reset");

    for (int n = 0; n < 20; n++) begin
      int         kind, len;
      logic [7:0] s, e;
      kind = $urandom_range(0, 9);
      if (kind <= 5) begin
        s   = ($urandom_range(0, 1) != 0) ? 8'hC7 : 8'h80;
        e   = ($urandom_range(0, 7) == 0) ? 8'h9C : ((s == 8'hC7) ? 8'hDA : 8'h9D);
        len = ($urandom_range(0, 1) != 0) ? 1440 : lens[$urandom_range(0, 5)];
      end else if (kind == 6) begin
        s   = ($urandom_range(0, 1) != 0) ? 8'hC6 : 8'h81;
        e   = 8'h9D;
        len = $urandom_range(20, 300);
      end else begin
        s   = ($urandom_range(0, 1) != 0) ? 8'hEC : 8'hAB;
        e   = ($urandom_range(0, 9) == 0) ? 8'hB7 : ((s == 8'hEC) ? 8'hF1 : 8'hB6);
        len = $urandom_range(20, 300);
      end
      run_line(s, len, e, 1'b1, $sformatf("rnd%0d", n));
    end

    chk("xy_err_pulses", err_pulses, m_err);
    chk("monitor_rules", mon_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
